// File: rtl/pipeline_biss_param.sv
// Configurable-depth add pipeline: stage k adds INC_BASE*INC_MULT^k (mod 2^WIDTH),
// with valid/ready backpressure, bubble collapsing, synchronous flush and occupancy.
module pipeline_biss_param #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned INC_BASE    = 10,
    parameter int unsigned INC_MULT    = 10,
    parameter bit          ZERO_BUBBLE = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    output logic [WIDTH-1:0]                out_data,
    input  logic                            out_ready,
    input  logic                            flush,
    output logic [$clog2(STAGES+1)-1:0]     occupancy
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    // Elaboration-time addend; each multiply truncates so the result is exact mod 2^WIDTH.
    function automatic logic [WIDTH-1:0] addend(input int unsigned k);
        logic [WIDTH-1:0] acc;
        acc = WIDTH'(INC_BASE);
        for (int unsigned i = 0; i < k; i++) begin
            acc = WIDTH'(acc * WIDTH'(INC_MULT));
        end
        return acc;
    endfunction

    logic [WIDTH-1:0] inc   [STAGES];
    logic [WIDTH-1:0] d     [STAGES];
    logic [WIDTH-1:0] d_nxt [STAGES];
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_nxt;
    logic [STAGES-1:0] adv;
    logic              take;
    logic              keep0;

    for (genvar k = 0; k < STAGES; k++) begin : g_inc
        localparam logic [WIDTH-1:0] A = addend(k);
        assign inc[k] = A;
    end

    // A stage may move when it is empty or the stage below it moves.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !v[STAGES-1] || out_ready;
        for (int unsigned i = 1; i < STAGES; i++) begin
            adv[STAGES-1-i] = !v[STAGES-1-i] || adv[STAGES-i];
        end
    end

    assign in_ready  = adv[0] && !flush;
    assign take      = in_valid && in_ready;
    // Legacy encoding: a zero operand completes the handshake but enters as a bubble.
    assign keep0     = take && !(ZERO_BUBBLE && (in_data == '0));
    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];

    always_comb begin
        v_nxt = v;
        d_nxt = d;
        if (adv[0]) begin
            v_nxt[0] = keep0;
            if (keep0) begin
                d_nxt[0] = in_data + inc[0];
            end
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
                v_nxt[i] = v[i-1];
                if (v[i-1]) begin
                    d_nxt[i] = d[i-1] + inc[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v         <= '0;
            occupancy <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_nxt;
            d         <= d_nxt;
            occupancy <= OCC_W'($countones(v_nxt));
        end
    end

endmodule

// File: tb/tb_pipeline_biss_param.sv
// Directed bench for pipeline_biss_param: default, zero-as-data, 1-stage and 8-stage builds.
module tb_pipeline_biss_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        d_in_ready, d_out_valid;
    logic [15:0] d_out_data;
    logic [1:0]  d_occ;
    logic        z_in_ready, z_out_valid;
    logic [15:0] z_out_data;
    logic [1:0]  z_occ;
    logic        s1_in_ready, s1_out_valid;
    logic [15:0] s1_out_data;
    logic [0:0]  s1_occ;
    logic        s8_in_ready, s8_out_valid;
    logic [15:0] s8_out_data;
    logic [3:0]  s8_occ;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_biss_param dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d_in_ready), .out_valid(d_out_valid), .out_data(d_out_data),
        .out_ready(out_ready), .flush(flush), .occupancy(d_occ)
    );

    pipeline_biss_param #(.ZERO_BUBBLE(1'b0)) u_nz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(z_in_ready), .out_valid(z_out_valid), .out_data(z_out_data),
        .out_ready(out_ready), .flush(flush), .occupancy(z_occ)
    );

    pipeline_biss_param #(.STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s1_in_ready), .out_valid(s1_out_valid), .out_data(s1_out_data),
        .out_ready(out_ready), .flush(flush), .occupancy(s1_occ)
    );

    pipeline_biss_param #(.STAGES(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s8_in_ready), .out_valid(s8_out_valid), .out_data(s8_out_data),
        .out_ready(out_ready), .flush(flush), .occupancy(s8_occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_out_valid", d_out_valid, 0);
        chk("rst_out_data",  d_out_data,  0);
        chk("rst_occ",       d_occ,       0);
        chk("rst_in_ready",  d_in_ready,  1);
        chk("rst_s8_occ",    s8_occ,      0);

        // Single word latency: 5 + 10 + 100 + 1000
        in_data = 16'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_occ0",   d_occ, 1);
        chk("lat_ov0",    d_out_valid, 0);
        chk("s1_ov",      s1_out_valid, 1);
        chk("s1_od",      s1_out_data, 15);
        chk("s8_occ0",    s8_occ, 1);
        tick();
        chk("lat_occ1",   d_occ, 1);
        chk("lat_ov1",    d_out_valid, 0);
        chk("s1_ov_gone", s1_out_valid, 0);
        tick();
        chk("lat_occ2",   d_occ, 1);
        chk("lat_ov2",    d_out_valid, 1);
        chk("lat_od2",    d_out_data, 1115);
        tick();
        chk("lat_occ3",   d_occ, 0);
        chk("lat_ov3",    d_out_valid, 0);
        tick(); tick(); tick();
        chk("s8_ov_early", s8_out_valid, 0);
        tick();
        chk("s8_ov",      s8_out_valid, 1);
        chk("s8_od",      s8_out_data, 27595);

        // Zero bubble: 7,0,9
        do_reset();
        in_valid = 1'b1; in_data = 16'd7;
        tick();
        in_data = 16'd0;
        #1;
        chk("zb_in_ready_zero", d_in_ready, 1);
        tick();
        in_data = 16'd9;
        tick();
        in_valid = 1'b0;
        chk("zb_ov_a",  d_out_valid, 1);
        chk("zb_od_a",  d_out_data, 1117);
        chk("nz_od_a",  z_out_data, 1117);
        tick();
        chk("zb_gap",   d_out_valid, 0);
        chk("nz_ov_b",  z_out_valid, 1);
        chk("nz_od_b",  z_out_data, 1110);
        tick();
        chk("zb_ov_c",  d_out_valid, 1);
        chk("zb_od_c",  d_out_data, 1119);
        chk("nz_od_c",  z_out_data, 1119);

        // Wrap: 65530 + 1110 mod 65536
        do_reset();
        in_valid = 1'b1; in_data = 16'd65530;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("wrap_ov", d_out_valid, 1);
        chk("wrap_od", d_out_data, 1104);

        // Backpressure
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd1;
        tick();
        in_data = 16'd2;
        #1;
        chk("bp_in_ready_1", d_in_ready, 1);
        tick();
        in_data = 16'd3;
        tick();
        in_data = 16'd4;
        #1;
        chk("bp_in_ready_full", d_in_ready, 0);
        chk("bp_occ_full",      d_occ, 3);
        chk("bp_od_hold",       d_out_data, 1111);
        tick();
        chk("bp_occ_stall",     d_occ, 3);
        chk("bp_od_stall",      d_out_data, 1111);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rel",  d_in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_od_1112", d_out_data, 1112);
        chk("bp_occ_a",   d_occ, 3);
        tick();
        chk("bp_od_1113", d_out_data, 1113);
        chk("bp_occ_b",   d_occ, 2);
        tick();
        chk("bp_od_1114", d_out_data, 1114);
        chk("bp_ov_1114", d_out_valid, 1);
        tick();
        chk("bp_empty_ov",  d_out_valid, 0);
        chk("bp_empty_occ", d_occ, 0);

        // Flush
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'd1; tick();
        in_data = 16'd2; tick();
        in_data = 16'd3; tick();
        flush = 1'b1; in_data = 16'd50;
        #1;
        chk("fl_in_ready", d_in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_ov",       d_out_valid, 0);
        chk("fl_occ",      d_occ, 0);
        chk("fl_d_kept",   d_out_data, 1111);
        in_valid = 1'b1; in_data = 16'd5;
        #1;
        chk("fl_in_ready_after", d_in_ready, 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_ov_early", d_out_valid, 0);
        tick();
        chk("fl_ov_new",   d_out_valid, 1);
        chk("fl_od_new",   d_out_data, 1115);

        // Reset mid-stream
        do_reset();
        in_valid = 1'b1;
        in_data = 16'd1; tick();
        in_data = 16'd2; tick();
        in_valid = 1'b0;
        chk("mr_occ_before", d_occ, 2);
        rst = 1'b0;
        tick();
        chk("mr_ov",  d_out_valid, 0);
        chk("mr_od",  d_out_data, 0);
        chk("mr_occ", d_occ, 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_no_stale", d_out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_biss_param.md
# pipeline_biss_param

Parametrised successor of the fixed three-stage add pipeline. It carries WIDTH-bit operands through STAGES registered stages. Stage k adds a compile-time constant. Unlike the fixed version, it uses explicit valid bits, valid/ready backpressure with bubble collapsing, a synchronous flush and an occupancy count. It sits between a producer and a consumer that can stall, and is used wherever the team needs a configurable-depth arithmetic pipe.

## Interface
- WIDTH, 16, operand/result width in bits (≥ 4)
- STAGES, 3, number of pipeline stages (1..16)
- INC_BASE, 10, addend of stage 0
- INC_MULT, 10, ratio between consecutive stage addends; stage k adds INC_BASE·INC_MULT^k mod 2^WIDTH
- ZERO_BUBBLE, 1, 1 = an input value of 0 is discarded (legacy bubble encoding); 0 = zero is ordinary data
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  producer offers in_data
- in_data  in  WIDTH  operand
- in_ready  out  1  stage 0 can take a word this cycle
- out_valid  out  1  last stage holds a result
- out_data  out  WIDTH  result
- out_ready  in  1  consumer takes out_data this cycle
- flush  in  1  discard everything in flight
- occupancy  out  clog2(STAGES+1)  number of valid stages

## Operation
- Each stage k (0..STAGES-1) holds a registered data word d[k] and a valid bit v[k].
- out_data = d[STAGES-1] and out_valid = v[STAGES-1].
- Advance conditions:
  - Last stage: adv[STAGES-1] = !v[STAGES-1] || out_ready.
  - Stage k < STAGES-1: adv[k] = !v[k] || adv[k+1]. A bubble in any stage lets upstream stages move while downstream stalls (bubble collapsing).
  - in_ready = adv[0] && !flush. It is combinational from out_ready and the valid bits. There is no path from in_valid.
- Accept: a word enters when in_valid && in_ready. With ZERO_BUBBLE=1 and in_data==0, the handshake still completes (in_ready reflects adv[0]), but stage 0 loads v=0. The word is consumed and dropped.
- Transfer on an enabled edge:
  - Stage 0: d[0] ← in_data + A0, v[0] ← accepted.
  - Stage k>0: d[k] ← d[k-1] + Ak, v[k] ← v[k-1].
  - Data is loaded only when the incoming valid is 1; bubble stages keep their old d but have v=0.
- Arithmetic: unsigned, result truncated to WIDTH bits (wraps mod 2^WIDTH). Addends are computed at elaboration time, mod 2^WIDTH.
- Stage output ordering is strictly FIFO; no reordering or duplication.
- occupancy = popcount(v), registered, always consistent with v after each edge.

## Timing
- Reset (rst=0 at an edge), highest priority:
  - all v ← 0, all d ← 0, occupancy ← 0.
  - Consequently out_valid=0, out_data=0, in_ready=1 (once rst=1, flush=0).
  - Reset mid-operation drops all in-flight data with no output.
- Flush (rst=1, flush=1), below reset:
  - all v ← 0, occupancy ← 0; d values unchanged.
  - in_ready=0 in the flush cycle, so no input is accepted.
  - out_ready is ignored; any handshake on out_valid in that cycle still counts as delivered.
- Latency: a word accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles from accept to visible result when unstalled.
- Throughput: one word per cycle with out_ready held high.
- Stall: while out_valid && !out_ready, the last stage holds data stable. Upstream stages fill bubbles; in_ready drops only when all STAGES are valid.
- Simultaneous accept and deliver with a full pipe: both occur in the same cycle and occupancy is unchanged.

## Test plan
- Defaults (addends 10/100/1000). Reset, then in_data=5 for one cycle, out_ready=1 → out_valid=1 with out_data=1115 exactly 3 cycles after accept; occupancy 1,1,1 then 0.
- Zero bubble: stream 7,0,9 with ZERO_BUBBLE=1 → outputs 1117 then 1119, with one out_valid=0 cycle between; with ZERO_BUBBLE=0 the middle output is 1110.
- Wrap: in_data=65530 → out_data=1104.
- Backpressure:
  - Hold out_ready=0 and stream 1,2,3,4 → in_ready falls after 3 accepts, occupancy=3, out_data stays 1111.
  - Release out_ready → 1111,1112,1113,1114 delivered on consecutive cycles, no loss or duplicate.
- Flush: fill with 3 words, assert flush one cycle with in_valid=1 → in_ready=0 that cycle; next cycle out_valid=0, occupancy=0; the next accepted word emerges after 3 cycles.
- Reset mid-stream: pull rst low while 2 words are in flight → next edge out_valid=0, out_data=0, occupancy=0; no stale result after release. Repeat with STAGES=1 and STAGES=8: latency equals STAGES.
